// File: rtl/limbus_sysid_ctrl.sv
// limbus_sysid_ctrl: post-reset (and optional periodic) self-check of the system-ID slave,
// sharing the slave with one Avalon-MM host read port. Define LIMBUS_SYSID_IRQ_EN for irq/irq_clr.
module limbus_sysid_ctrl #(
    parameter logic [31:0] EXP_ID         = 32'd666,
    parameter logic [31:0] EXP_TS         = 32'd1354828801,
    parameter int unsigned RECHECK_CYCLES = 0,
    parameter int unsigned CNT_W          = 8
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              host_read,
    input  logic              host_address,
    output logic              host_waitrequest,
    output logic [31:0]       host_readdata,
    output logic              host_readdatavalid,
    output logic              sysid_address,
    input  logic [31:0]       sysid_readdata,
    output logic              check_done,
    output logic              id_ok,
    output logic              ts_ok,
    output logic [31:0]       id_value,
    output logic [31:0]       ts_value,
    output logic [CNT_W-1:0]  mismatch_cnt
`ifdef LIMBUS_SYSID_IRQ_EN
    ,
    output logic              irq,
    input  logic              irq_clr
`endif
);

    typedef enum logic [2:0] {
        ID_ADDR,
        ID_CAP,
        TS_ADDR,
        TS_CAP,
        CMP,
        DONE,
        HOST_CAP
    } state_t;

    localparam int unsigned     RC_W       = (RECHECK_CYCLES > 1) ? $clog2(RECHECK_CYCLES) : 1;
    localparam bit              RECHECK_EN = (RECHECK_CYCLES != 0);
    localparam logic [RC_W-1:0] RC_LAST    = RECHECK_EN ? RC_W'(RECHECK_CYCLES - 1) : '0;

    state_t            state_q;
    logic              sysid_addr_q;
    logic [31:0]       id_value_q;
    logic [31:0]       ts_value_q;
    logic [31:0]       rdata_q;
    logic              rdv_q;
    logic              done_q;
    logic              id_ok_q;
    logic              ts_ok_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_d;
    logic [RC_W-1:0]   recheck_q;
    logic              mismatch;
    logic              recheck_due;
`ifdef LIMBUS_SYSID_IRQ_EN
    logic              irq_q;
`endif

    always_comb begin
        mismatch    = (id_value_q != EXP_ID) || (ts_value_q != EXP_TS);
        recheck_due = RECHECK_EN && (recheck_q == RC_LAST);
        cnt_d       = cnt_q;
        if (mismatch && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ID_ADDR;
            sysid_addr_q <= 1'b0;
            id_value_q   <= '0;
            ts_value_q   <= '0;
            rdata_q      <= '0;
            rdv_q        <= 1'b0;
            done_q       <= 1'b0;
            id_ok_q      <= 1'b0;
            ts_ok_q      <= 1'b0;
            cnt_q        <= '0;
            recheck_q    <= '0;
`ifdef LIMBUS_SYSID_IRQ_EN
            irq_q        <= 1'b0;
`endif
        end else begin
            rdv_q <= 1'b0;
`ifdef LIMBUS_SYSID_IRQ_EN
            // A set in CMP below overrides this clear when both happen together.
            if (irq_clr) begin
                irq_q <= 1'b0;
            end
`endif
            case (state_q)
                ID_ADDR: begin
                    sysid_addr_q <= 1'b0;
                    state_q      <= ID_CAP;
                end
                ID_CAP: begin
                    id_value_q <= sysid_readdata;
                    state_q    <= TS_ADDR;
                end
                TS_ADDR: begin
                    sysid_addr_q <= 1'b1;
                    state_q      <= TS_CAP;
                end
                TS_CAP: begin
                    ts_value_q <= sysid_readdata;
                    state_q    <= CMP;
                end
                CMP: begin
                    id_ok_q <= (id_value_q == EXP_ID);
                    ts_ok_q <= (ts_value_q == EXP_TS);
                    cnt_q   <= cnt_d;
                    done_q  <= 1'b1;
`ifdef LIMBUS_SYSID_IRQ_EN
                    if (mismatch) begin
                        irq_q <= 1'b1;
                    end
`endif
                    state_q <= DONE;
                end
                DONE: begin
                    // Host reads freeze the recheck timer, so an expiry that collides with a read fires on the next idle DONE cycle.
                    if (host_read) begin
                        sysid_addr_q <= host_address;
                        state_q      <= HOST_CAP;
                    end else if (recheck_due) begin
                        recheck_q <= '0;
                        state_q   <= ID_ADDR;
                    end else if (RECHECK_EN) begin
                        recheck_q <= recheck_q + RC_W'(1);
                    end
                end
                HOST_CAP: begin
                    rdata_q <= sysid_readdata;
                    rdv_q   <= 1'b1;
                    state_q <= DONE;
                end
                default: begin
                    state_q <= ID_ADDR;
                end
            endcase
        end
    end

    assign host_waitrequest   = (state_q != DONE);
    assign host_readdata      = rdata_q;
    assign host_readdatavalid = rdv_q;
    assign sysid_address      = sysid_addr_q;
    assign check_done         = done_q;
    assign id_ok              = id_ok_q;
    assign ts_ok              = ts_ok_q;
    assign id_value           = id_value_q;
    assign ts_value           = ts_value_q;
    assign mismatch_cnt       = cnt_q;
`ifdef LIMBUS_SYSID_IRQ_EN
    assign irq                = irq_q;
`endif

endmodule

// File: doc/limbus_sysid_ctrl.md
Name: limbus_sysid_ctrl

Overview:
Controller that owns the system-ID slave, a zero-wait combinational read-only block with a 1-bit address: address 0 returns the ID word, address 1 returns the build timestamp.
- After reset, sequences reads of both words, compares them against expected values and publishes sticky status.
- Optionally re-checks periodically.
- Shares the slave with one Avalon-MM host read port; the internal sequencer has priority while its read is active.

Parameters:
EXP_ID, 32'd666, expected ID word (address 0)
EXP_TS, 32'd1354828801, expected timestamp word (address 1)
RECHECK_CYCLES, 0, cycles from DONE to automatic re-check; 0 = check once after reset only
CNT_W, 8, width of mismatch counter

Ports:
clock  in  1  system clock, all logic rising-edge
reset_n  in  1  asynchronous active-low reset
host_read  in  1  host read strobe
host_address  in  1  host word select (0 = ID, 1 = timestamp)
host_waitrequest  out  1  host read not accepted this cycle
host_readdata  out  32  registered read data
host_readdatavalid  out  1  one-cycle pulse, host_readdata valid
sysid_address  out  1  registered address to sysid slave
sysid_readdata  in  32  combinational data from sysid slave
check_done  out  1  at least one check sequence completed
id_ok  out  1  last captured ID == EXP_ID
ts_ok  out  1  last captured timestamp == EXP_TS
id_value  out  32  last captured ID word
ts_value  out  32  last captured timestamp word
mismatch_cnt  out  CNT_W  saturating count of failed checks
irq  out  1  only with LIMBUS_SYSID_IRQ_EN
irq_clr  in  1  only with LIMBUS_SYSID_IRQ_EN

Behaviour:
- Reset values: all outputs 0, with one exception: host_waitrequest = 1. FSM state = ID_ADDR. Asynchronous assert, synchronous release.
- FSM states: ID_ADDR, ID_CAP, TS_ADDR, TS_CAP, CMP, DONE, HOST_CAP.
- ID_ADDR: sysid_address <= 0; next state ID_CAP.
- ID_CAP: id_value <= sysid_readdata; next state TS_ADDR.
- TS_ADDR: sysid_address <= 1; next state TS_CAP.
- TS_CAP: ts_value <= sysid_readdata; next state CMP.
- CMP:
  - id_ok <= (id_value == EXP_ID); ts_ok <= (ts_value == EXP_TS).
  - If either compare fails: mismatch_cnt += 1, saturating at all-ones.
  - check_done <= 1; next state DONE.
- Check latency: reset release to check_done = 1 is 5 cycles.
- DONE:
  - host_waitrequest = 0 (combinational from state).
  - If host_read: sysid_address <= host_address; next state HOST_CAP.
  - Else if RECHECK_CYCLES != 0 and recheck counter reaches RECHECK_CYCLES-1: go to ID_ADDR.
  - Recheck counter clears on leaving DONE. It holds while in HOST_CAP and does not restart.
- HOST_CAP:
  - host_readdata <= sysid_readdata; host_readdatavalid pulses next cycle; next state DONE.
  - host_waitrequest = 1 in this state.
- Host timing: read accepted in cycle N; readdatavalid in cycle N+2. Maximum throughput is one read per 2 cycles.
- Host is stalled (waitrequest = 1) in every state except DONE; host_read held across the stall is accepted on DONE entry.
- Simultaneous host_read and recheck expiry in DONE: host wins; the recheck runs on the next DONE cycle.
- status during recheck: id_ok, ts_ok, check_done hold their previous values until CMP updates them; id_value and ts_value update at capture.
- host_readdatavalid is asserted only for host reads, never for internal sequence reads.
- Reset mid-sequence or mid-host-read: in-flight read is dropped, no readdatavalid is generated, and the sequence restarts from ID_ADDR.

Optional Feature:
LIMBUS_SYSID_IRQ_EN:
- Defined: ports irq and irq_clr exist. irq sets in CMP on mismatch and is sticky until irq_clr = 1. Set and clear in the same cycle: set wins. Reset value 0.
- Undefined: ports irq and irq_clr are absent; no interrupt logic is built.

Test Plan:
1. Slave returns 666 / 1354828801; release reset -> check_done = 1 at cycle 5, id_ok = 1, ts_ok = 1, mismatch_cnt = 0.
2. Slave ID word = 667 -> id_ok = 0, ts_ok = 1, mismatch_cnt = 1, id_value = 667; with IRQ_EN, irq = 1 until irq_clr pulse, then 0.
3. Host read addr 1 in DONE at cycle N -> host_readdatavalid at N+2 with 1354828801; waitrequest = 1 at N+1; back-to-back read accepted at N+2.
4. Host read held during reset sequence -> waitrequest = 1 until DONE; single readdatavalid with correct word.
5. RECHECK_CYCLES = 16, ID mismatch persistent -> mismatch_cnt increments every 21 cycles (16 in DONE + 5 for the sequence), saturates at 255 with CNT_W = 8.
6. Host read coincident with recheck expiry -> host data returned first; sequence starts next DONE cycle; reset asserted mid-HOST_CAP -> no readdatavalid.
